// File: rtl/btb_predictor_param.sv
// btb_predictor_param
// Direct-mapped branch target buffer with a per-entry valid bit, tag, target
// and saturating direction counter. It also keeps a saturating mispredict
// counter.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   lkp_valid, lkp_pc  fetch lookup; response registered one cycle later
//   rsp_valid          response valid (follows lkp_valid by one cycle)
//   rsp_hit            entry valid and tag matches
//   rsp_taken          hit and counter MSB set
//   rsp_target         stored target on hit, else 0
//   rsp_cnt            stored counter on hit, else 0
//   upd_valid, upd_pc, upd_taken, upd_target
//                      branch resolution update
//   flush              invalidate every entry
//   stat_mispred       saturating count of mispredicting updates
module btb_predictor_param #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lkp_valid,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_taken,
    output logic [ADDR_W-1:0] rsp_target,
    output logic [CNT_W-1:0]  rsp_cnt,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic [15:0]       stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W;

    localparam logic [CNT_W-1:0] WNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic              entryValid [ENTRIES];
    logic [TAG_W-1:0]  tagMem     [ENTRIES];
    logic [ADDR_W-1:0] targetMem  [ENTRIES];
    logic [CNT_W-1:0]  cntMem     [ENTRIES];

    logic [IDX_W-1:0]  updIdx;
    logic [TAG_W-1:0]  updTag;
    logic              updHit;
    logic [CNT_W-1:0]  updCnt;
    logic              predTaken;
    logic              mispredict;
    logic              updWrite;
    logic [CNT_W-1:0]  nextCnt;
    logic [ADDR_W-1:0] nextTarget;

    logic [IDX_W-1:0]  lkpIdx;
    logic [TAG_W-1:0]  lkpTag;
    logic              bypass;
    logic              entValid;
    logic [TAG_W-1:0]  entTag;
    logic [ADDR_W-1:0] entTarget;
    logic [CNT_W-1:0]  entCnt;
    logic              lkpHit;

    // Update side: evaluated on the pre-update entry
    always_comb begin
        updIdx     = upd_pc[IDX_W-1:0];
        updTag     = upd_pc[ADDR_W-1:IDX_W];
        updCnt     = cntMem[updIdx];
        updHit     = entryValid[updIdx] && (tagMem[updIdx] == updTag);
        predTaken  = updHit && updCnt[CNT_W-1];
        // The mispredict is counted even when a flush drops the write
        mispredict = upd_valid &&
                     ((predTaken != upd_taken) ||
                      (predTaken && upd_taken && (targetMem[updIdx] != upd_target)));
        // Not-taken misses are never allocated
        updWrite   = upd_valid && !flush && (updHit || upd_taken);

        nextCnt = WT;
        if (updHit) begin
            if (upd_taken)
                nextCnt = (updCnt == MAX) ? updCnt : updCnt + 1'b1;
            else
                nextCnt = (updCnt == '0) ? updCnt : updCnt - 1'b1;
        end
        nextTarget = upd_taken ? upd_target : targetMem[updIdx];
    end

    // Lookup side: write-first bypass so a same-index update is visible
    always_comb begin
        lkpIdx    = lkp_pc[IDX_W-1:0];
        lkpTag    = lkp_pc[ADDR_W-1:IDX_W];
        bypass    = updWrite && (updIdx == lkpIdx);
        entValid  = bypass ? 1'b1       : entryValid[lkpIdx];
        entTag    = bypass ? updTag     : tagMem[lkpIdx];
        entTarget = bypass ? nextTarget : targetMem[lkpIdx];
        entCnt    = bypass ? nextCnt    : cntMem[lkpIdx];
        lkpHit    = !flush && entValid && (entTag == lkpTag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entryValid[i] <= 1'b0;
                tagMem[i]     <= '0;
                targetMem[i]  <= '0;
                cntMem[i]     <= WNT;
            end
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_taken    <= 1'b0;
            rsp_target   <= '0;
            rsp_cnt      <= '0;
            stat_mispred <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++)
                    entryValid[i] <= 1'b0;
            end else if (updWrite) begin
                entryValid[updIdx] <= 1'b1;
                tagMem[updIdx]     <= updTag;
                targetMem[updIdx]  <= nextTarget;
                cntMem[updIdx]     <= nextCnt;
            end

            if (mispredict && (stat_mispred != 16'hFFFF))
                stat_mispred <= stat_mispred + 16'd1;

            rsp_valid <= lkp_valid;
            if (lkp_valid) begin
                rsp_hit    <= lkpHit;
                rsp_taken  <= lkpHit && entCnt[CNT_W-1];
                rsp_target <= lkpHit ? entTarget : '0;
                rsp_cnt    <= lkpHit ? entCnt : '0;
            end
        end
    end

endmodule
